gemm_result_writer: RTL and testbench

//  Receive end of the GeMM result stream: captures each result_valid tile (M x N outputs) from the

---
 rtl/gemm_result_writer.sv | 190 +++++++++++++++++++
 tb/tb_gemm_result_writer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_result_writer.sv
// GeMM result tile FIFO + row writer into C SRAM; GEMM_RESULT_WRITER_STATS_EN builds the stall counter.
// Latency: tile push -> sram_req_o next cycle; no input backpressure (full FIFO drops tile, sets overflow_o), SRAM backpressure via sram_gnt_i.
module gemm_result_writer #(
  parameter int AddrWidth = 16,
  parameter int DataWidth = 32,
  parameter int M         = 4,
  parameter int N         = 4,
  parameter int FifoDepth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [AddrWidth-1:0]       M_size_i,
  input  logic [AddrWidth-1:0]       N_size_i,
  input  logic                       result_valid_i,
  input  logic [M*N*DataWidth-1:0]   result_data_i,
  output logic                       sram_req_o,
  output logic                       sram_we_o,
  output logic [AddrWidth-1:0]       sram_addr_o,
  output logic [N*DataWidth-1:0]     sram_wdata_o,
  input  logic                       sram_gnt_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       overflow_o,
  output logic [AddrWidth-1:0]       stall_cnt_o
);

  localparam int RowW  = N * DataWidth;
  localparam int TileW = M * N * DataWidth;
  localparam int RW    = (M > 1) ? $clog2(M) : 1;
  localparam int PW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CW    = PW + 1;
  localparam logic [AddrWidth-1:0] MW = AddrWidth'(M);
  localparam logic [AddrWidth-1:0] NW = AddrWidth'(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] tn_q, tn_d;
  logic [AddrWidth-1:0] total_q, total_d;
  logic [AddrWidth-1:0] mt_q, mt_d;
  logic [AddrWidth-1:0] nt_q, nt_d;
  logic [AddrWidth-1:0] written_q, written_d;
  logic [RW-1:0]        r_q, r_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [TileW-1:0]     fifo_mem [FifoDepth];
  logic [TileW-1:0]     head;
  logic                 full, empty, req, last_row, pop, push;
  logic [AddrWidth-1:0] addr_raw;

  assign full     = (count_q == CW'(FifoDepth));
  assign empty    = (count_q == '0);
  assign req      = (state_q == RUN) && !empty;
  assign last_row = (r_q == RW'(M - 1));
  assign pop      = req && sram_gnt_i && last_row;
  // A full FIFO still accepts a tile when its head retires in the same cycle.
  assign push     = (state_q == RUN) && result_valid_i && (!full || pop);
  assign head     = fifo_mem[rd_ptr_q];
  assign addr_raw = (mt_q * MW + AddrWidth'(r_q)) * tn_q + nt_q;

  assign sram_req_o   = req;
  assign sram_we_o    = req;
  assign sram_addr_o  = req ? addr_raw : '0;
  assign sram_wdata_o = req ? head[r_q*RowW +: RowW] : '0;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign overflow_o   = overflow_q;

  always_comb begin
    state_d    = state_q;
    tn_d       = tn_q;
    total_d    = total_q;
    mt_d       = mt_q;
    nt_d       = nt_q;
    written_d  = written_q;
    r_d        = r_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d    = RUN;
          tn_d       = N_size_i / NW;
          total_d    = (M_size_i / MW) * (N_size_i / NW);
          mt_d       = '0;
          nt_d       = '0;
          written_d  = '0;
          r_d        = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          overflow_d = 1'b0;
        end
      end
      RUN: begin
        if (written_q == total_q && empty) state_d = DONE;
        if (req && sram_gnt_i) begin
          if (last_row) begin
            r_d       = '0;
            rd_ptr_d  = rd_ptr_q + PW'(1);
            written_d = written_q + AddrWidth'(1);
            if (nt_q == tn_q - AddrWidth'(1)) begin
              nt_d = '0;
              mt_d = mt_q + AddrWidth'(1);
            end else begin
              nt_d = nt_q + AddrWidth'(1);
            end
          end else begin
            r_d = r_q + RW'(1);
          end
        end
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        case ({push, pop})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
        if (result_valid_i && full && !pop) overflow_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      tn_q       <= '0;
      total_q    <= '0;
      mt_q       <= '0;
      nt_q       <= '0;
      written_q  <= '0;
      r_q        <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tn_q       <= tn_d;
      total_q    <= total_d;
      mt_q       <= mt_d;
      nt_q       <= nt_d;
      written_q  <= written_d;
      r_q        <= r_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Tile storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= result_data_i;
  end

`ifdef GEMM_RESULT_WRITER_STATS_EN
  logic [AddrWidth-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start_i) stall_d = '0;
    else if (req && !sram_gnt_i && stall_q != '1) stall_d = stall_q + AddrWidth'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_gemm_result_writer.sv
// Scoreboard bench for gemm_result_writer: stimulus queues expected SRAM writes, a forked monitor retires them.
module tb_gemm_result_writer;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int FD = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     m_size, n_size;
  logic              result_valid;
  logic [M*N*DW-1:0] result_data;
  logic              sram_req, sram_we, sram_gnt;
  logic [AW-1:0]     sram_addr;
  logic [N*DW-1:0]   sram_wdata;
  logic              busy, done, overflow;
  logic [AW-1:0]     stall_cnt;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [N*DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total_chk = 0;
  int  bad       = 0;
  int  done_cnt  = 0;
  int  wr_cnt    = 0;
  int  d0, w0, stall_exp;

  always #5 clk = ~clk;

  gemm_result_writer #(.AddrWidth(AW), .DataWidth(DW), .M(M), .N(N), .FifoDepth(FD)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .M_size_i(m_size), .N_size_i(n_size),
    .result_valid_i(result_valid), .result_data_i(result_data),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_gnt_i(sram_gnt), .busy_o(busy), .done_o(done),
    .overflow_o(overflow), .stall_cnt_o(stall_cnt)
  );

  function automatic logic [DW-1:0] elem(int tag, int k, int r, int c);
    return (DW'(tag) << 16) | (DW'(k) << 8) | (DW'(r) << 4) | DW'(c);
  endfunction

  function automatic logic [N*DW-1:0] row_exp(int tag, int k, int r);
    logic [N*DW-1:0] v;
    for (int c = 0; c < N; c++) v[c*DW +: DW] = elem(tag, k, r, c);
    return v;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    total_chk++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(int ms, int ns);
    m_size = AW'(ms);
    n_size = AW'(ns);
    start  = 1'b1;
    cycle();
    start  = 1'b0;
  endtask

  // Tile k of a job with tn tile columns lands at rows mt*M+r, column nt of C.
  task automatic send_tile(int tag, int k, int tn, bit stored);
    logic [M*N*DW-1:0] t;
    wr_t w;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++) t[(r*N+c)*DW +: DW] = elem(tag, k, r, c);
    if (stored)
      for (int r = 0; r < M; r++) begin
        w.addr = AW'(((k / tn) * M + r) * tn + (k % tn));
        w.data = row_exp(tag, k, r);
        exp_q.push_back(w);
      end
    result_data  = t;
    result_valid = 1'b1;
    cycle();
    result_valid = 1'b0;
  endtask

  task automatic wait_done(string name);
    int  base = done_cnt;
    bit  got  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (done_cnt != base) begin
        got = 1'b1;
        break;
      end
    end
    check(name, 128'(got), 128'd1);
  endtask

  task automatic monitor();
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else begin
        if (done) done_cnt++;
        if (sram_req) check("we_eq_req", 128'(sram_we), 128'd1);
        if (sram_req && sram_gnt) begin
          wr_cnt++;
          if (exp_q.size() == 0) begin
            total_chk++;
            bad++;
            $display("FAIL unexpected_write: got addr %0h expected none", sram_addr);
          end else begin
            w = exp_q.pop_front();
            check("wr_addr", 128'(sram_addr), 128'(w.addr));
            check("wr_data", 128'(sram_wdata), 128'(w.data));
          end
        end
      end
    end
  endtask

  task automatic check_all_zero(string name);
    check({name, "_req"}, 128'(sram_req), 128'd0);
    check({name, "_we"}, 128'(sram_we), 128'd0);
    check({name, "_addr"}, 128'(sram_addr), 128'd0);
    check({name, "_wdata"}, 128'(sram_wdata), 128'd0);
    check({name, "_busy"}, 128'(busy), 128'd0);
    check({name, "_done"}, 128'(done), 128'd0);
    check({name, "_ovf"}, 128'(overflow), 128'd0);
    check({name, "_stall"}, 128'(stall_cnt), 128'd0);
  endtask

  initial begin
`ifdef GEMM_RESULT_WRITER_STATS_EN
    stall_exp = 3;
`else
    stall_exp = 0;
`endif
    rst_n = 1'b0; start = 1'b0; m_size = '0; n_size = '0;
    result_valid = 1'b0; result_data = '0; sram_gnt = 1'b0;
    fork
      monitor();
    join_none
    cycle();
    check_all_zero("reset");
    cycle();
    rst_n = 1'b1;
    cycle();

    // 8x8 job, grant always high: 16 writes in controller tile order.
    sram_gnt = 1'b1;
    d0 = done_cnt;
    start_job(8, 8);
    for (int k = 0; k < 4; k++) send_tile(1, k, 2, 1'b1);
    wait_done("t1_done");
    check("t1_drained", 128'(exp_q.size()), 128'd0);
    check("t1_busy_after", 128'(busy), 128'd0);
    check("t1_ovf", 128'(overflow), 128'd0);
    repeat (3) cycle();
    check("t1_done_once", 128'(done_cnt - d0), 128'd1);

    // First row held three cycles without grant.
    sram_gnt = 1'b0;
    start_job(8, 8);
    send_tile(2, 0, 2, 1'b1);
    @(negedge clk);
    check("t2_req", 128'(sram_req), 128'd1);
    check("t2_addr_hold", 128'(sram_addr), 128'd0);
    check("t2_data_hold", 128'(sram_wdata), 128'(row_exp(2, 0, 0)));
    repeat (2) begin
      @(negedge clk);
      check("t2_addr_hold", 128'(sram_addr), 128'd0);
      check("t2_data_hold", 128'(sram_wdata), 128'(row_exp(2, 0, 0)));
    end
    @(posedge clk);
    #1 sram_gnt = 1'b1;
    for (int k = 1; k < 4; k++) send_tile(2, k, 2, 1'b1);
    wait_done("t2_done");
    check("t2_drained", 128'(exp_q.size()), 128'd0);
    check("t2_stall_cnt", 128'(stall_cnt), 128'(stall_exp));

    // 8x16 job (8 tiles), FIFO overrun with grant low: 5th tile dropped.
    sram_gnt = 1'b0;
    d0 = done_cnt;
    w0 = wr_cnt;
    start_job(8, 16);
    for (int k = 0; k < 5; k++) send_tile(3, k, 4, k < 4);
    check("t3_ovf_set", 128'(overflow), 128'd1);
    check("t3_no_writes", 128'(wr_cnt - w0), 128'd0);
    sram_gnt = 1'b1;
    repeat (30) cycle();
    check("t3_drained", 128'(exp_q.size()), 128'd0);
    check("t3_written", 128'(wr_cnt - w0), 128'd16);
    check("t3_ovf_sticky", 128'(overflow), 128'd1);
    check("t3_no_done", 128'(done_cnt - d0), 128'd0);
    check("t3_busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Reset in the middle of tile 1, then a clean job.
    w0 = wr_cnt;
    start_job(8, 8);
    send_tile(4, 0, 2, 1'b1);
    send_tile(4, 1, 2, 1'b1);
    for (int i = 0; i < 40 && (wr_cnt - w0) < 6; i++) cycle();
    check("t4_mid_tile1", 128'((wr_cnt - w0) >= 6), 128'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t4_rst");
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    d0 = done_cnt;
    start_job(8, 8);
    for (int k = 0; k < 4; k++) send_tile(5, k, 2, 1'b1);
    wait_done("t4_done");
    check("t4_drained", 128'(exp_q.size()), 128'd0);
    check("t4_done_once", 128'(done_cnt - d0), 128'd1);

    // Empty job: done in the second cycle after start, no SRAM traffic.
    w0 = wr_cnt;
    start_job(0, 8);
    check("t5_done_c1", 128'(done), 128'd0);
    check("t5_busy_c1", 128'(busy), 128'd1);
    cycle();
    check("t5_done_c2", 128'(done), 128'd1);
    cycle();
    check("t5_done_c3", 128'(done), 128'd0);
    check("t5_busy_c3", 128'(busy), 128'd0);
    check("t5_no_writes", 128'(wr_cnt - w0), 128'd0);

    // Start pulse during RUN must not disturb the job.
    d0 = done_cnt;
    start_job(8, 8);
    send_tile(6, 0, 2, 1'b1);
    send_tile(6, 1, 2, 1'b1);
    start_job(4, 4);
    send_tile(6, 2, 2, 1'b1);
    send_tile(6, 3, 2, 1'b1);
    wait_done("t6_done");
    check("t6_drained", 128'(exp_q.size()), 128'd0);
    repeat (3) cycle();
    check("t6_done_once", 128'(done_cnt - d0), 128'd1);

    $display("test done: total=%0d bad=%0d", total_chk, bad);
    $finish;
  end
endmodule
